// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan controller.
//  SEG_BLANK  all cathodes off (active-low bus)
//  SEG_A..P   bit positions inside a segment byte {p,g,f,e,d,c,b,a}
//  hex2seg    nibble -> active-high gfedcba glyph
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_P = 7;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to 7-segment glyph.
//  hex  in  4  nibble
//  seg  out 7  active-high gfedcba
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: self-timed N-digit multiplexed 7-segment driver with
// hex/raw modes, per-digit blink, 16-step PWM brightness and dead time.
//  clk, rst        clock, async active-high reset
//  hexs, seg_raw   per-digit nibble / raw byte sources (shadowed per frame)
//  points,blink_en per-digit dp request / blink enable (shadowed)
//  mode            1 = hex text, 0 = raw graphic (shadowed)
//  bright          PWM duty (bright+1)/16, live
//  an, segment     active-low anode / cathode pins, registered
//  frame_tick      1-cycle pulse as the scan returns to digit 0
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 4,
  parameter int BLINK_FR = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] hexs,
  input  logic [8*N_DIGITS-1:0] seg_raw,
  input  logic [N_DIGITS-1:0]   points,
  input  logic [N_DIGITS-1:0]   blink_en,
  input  logic                  mode,
  input  logic [3:0]            bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            segment,
  output logic                  frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = $clog2(BLINK_FR + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD     = PW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FR - 1);

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    pwm_cnt;

  // Display reads only these copies so a frame never mixes old and new data.
  logic [N_DIGITS-1:0][3:0] hex_sh;
  logic [N_DIGITS-1:0][7:0] raw_sh;
  logic [N_DIGITS-1:0]      points_sh;
  logic [N_DIGITS-1:0]      blink_sh;
  logic                     mode_sh;

  logic          slot_end, frame_end, dead, blank, pwm_on;
  logic [6:0]    dec;
  logic [7:0]    pat, seg_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign dead      = (pre < DEAD);
  assign blank     = blink_sh[idx] & blink_phase;
  assign pwm_on    = (pwm_cnt <= bright);

  seg7_hex_decode u_dec (
    .hex (hex_sh[idx]),
    .seg (dec)
  );

  always_comb begin
    pat = raw_sh[idx];
    if (mode_sh) begin
      pat[SEG_P]         = points_sh[idx];
      pat[SEG_G:SEG_A]   = dec;
    end
    seg_nxt = (dead || blank) ? SEG_BLANK : ~pat;
    an_nxt  = '1;
    if (!dead && pwm_on && !blank) an_nxt[idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre         <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
      hex_sh      <= '0;
      raw_sh      <= '0;
      points_sh   <= '0;
      blink_sh    <= '0;
      mode_sh     <= 1'b0;
      an          <= '1;
      segment     <= SEG_BLANK;
      frame_tick  <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 4'd1;
      an         <= an_nxt;
      segment    <= seg_nxt;
      frame_tick <= frame_end;
      if (slot_end) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        pre <= pre + PW'(1);
      end
      // Shadow load, blink step and digit wrap all land on the same edge.
      if (frame_end) begin
        hex_sh    <= hexs;
        raw_sh    <= seg_raw;
        points_sh <= points;
        blink_sh  <= blink_en;
        mode_sh   <= mode;
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  localparam int N = 4, S = 8, D = 2, B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] hexs = '0;
  logic [31:0] seg_raw = '0;
  logic [3:0]  points = '0, blink_en = '0;
  logic        mode = 1'b0;
  logic [3:0]  bright = 4'd15;
  logic [3:0]  an;
  logic [7:0]  segment;
  logic        frame_tick;

  seg7_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(S), .DEAD_CYC(D), .BLINK_FR(B)) dut (
    .clk(clk), .rst(rst), .hexs(hexs), .seg_raw(seg_raw), .points(points),
    .blink_en(blink_en), .mode(mode), .bright(bright), .an(an),
    .segment(segment), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: expected registered outputs queued at each edge.
  typedef struct { logic [3:0] an; logic [7:0] seg; logic ft; } exp_t;
  exp_t q[$];

  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int m_pre, m_idx, m_pwm, m_bcnt;
  logic m_phase, s_mode;
  logic [15:0] s_hexs;
  logic [31:0] s_raw;
  logic [3:0]  s_pts, s_blk;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_pre = 0; m_idx = 0; m_pwm = 0; m_bcnt = 0; m_phase = 0;
      s_mode = 0; s_hexs = '0; s_raw = '0; s_pts = '0; s_blk = '0;
      e.an = 4'hF; e.seg = 8'hFF; e.ft = 1'b0;
    end else begin
      logic dead_w, blank_w;
      dead_w  = (m_pre < D);
      blank_w = s_blk[m_idx] & m_phase;
      e.an = 4'hF;
      if (!dead_w && (m_pwm <= int'(bright)) && !blank_w) e.an[m_idx] = 1'b0;
      if (dead_w || blank_w) e.seg = 8'hFF;
      else if (s_mode)       e.seg = ~{s_pts[m_idx], HEX[s_hexs[m_idx*4 +: 4]]};
      else                   e.seg = ~s_raw[m_idx*8 +: 8];
      e.ft = (m_pre == S-1) && (m_idx == N-1);
      m_pwm = (m_pwm + 1) % 16;
      if (m_pre == S-1) begin
        m_pre = 0;
        if (m_idx == N-1) begin
          m_idx = 0;
          s_mode = mode; s_hexs = hexs; s_raw = seg_raw; s_pts = points; s_blk = blink_en;
          if (m_bcnt == B-1) begin m_bcnt = 0; m_phase = ~m_phase; end
          else m_bcnt++;
        end else m_idx++;
      end else m_pre++;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_an", 32'(an), 32'(e.an));
      chk("sb_seg", 32'(segment), 32'(e.seg));
      chk("sb_ft", 32'(frame_tick), 32'(e.ft));
    end
  end

  task automatic skip(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ft();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_tick && n < 200);
    if (!frame_tick) chk("ft_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cnt [4];
    logic [7:0] segs [4];
    int fts, lit0;

    // reset and first active slot
    skip(3);
    rst = 1'b0;
    skip(1); chk("rel_c1_an", 32'(an), 32'hF);
    skip(1); chk("rel_c2_an", 32'(an), 32'hF);
    skip(1); chk("rel_c3_an", 32'(an), 32'hE);
    chk("rel_c3_seg", 32'(segment), 32'hFF);

    // hex text scan
    mode = 1'b1; hexs = 16'h3210;
    wait_ft(); wait_ft();
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; segs[i] = 8'h00; end
    fts = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (frame_tick) fts++;
      for (int i = 0; i < 4; i++)
        if (an == ~(4'b0001 << i)) begin cnt[i]++; segs[i] = segment; end
    end
    chk("t2_cnt0", 32'(cnt[0]), 32'd6);
    chk("t2_cnt1", 32'(cnt[1]), 32'd6);
    chk("t2_cnt2", 32'(cnt[2]), 32'd6);
    chk("t2_cnt3", 32'(cnt[3]), 32'd6);
    chk("t2_seg0", 32'(segs[0]), 32'hC0);
    chk("t2_seg1", 32'(segs[1]), 32'hF9);
    chk("t2_seg2", 32'(segs[2]), 32'hA4);
    chk("t2_seg3", 32'(segs[3]), 32'hB0);
    chk("t2_ft_per_frame", 32'(fts), 32'd1);

    // decimal point
    points = 4'b0010;
    wait_ft(); skip(12);
    chk("t3_dp_an", 32'(an), 32'hD);
    chk("t3_dp_seg", 32'(segment), 32'h79);

    // mid-frame update stays hidden until next frame
    hexs = 16'h7654;
    skip(18);
    chk("t4_old_an", 32'(an), 32'h7);
    chk("t4_old_seg", 32'(segment), 32'hB0);
    wait_ft(); skip(4);
    chk("t4_new_an", 32'(an), 32'hE);
    chk("t4_new_seg", 32'(segment), 32'h99);

    // graphic mode
    mode = 1'b0; seg_raw = 32'h0081_0000;
    wait_ft(); skip(20);
    chk("t3_raw_an", 32'(an), 32'hB);
    chk("t3_raw_seg", 32'(segment), 32'h7E);

    // blink: digit0 lit in 2 of every 4 frames
    mode = 1'b1; blink_en = 4'b0001;
    wait_ft();
    lit0 = 0;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      if (an == 4'hE) lit0++;
    end
    chk("t5_blink_lit", 32'(lit0), 32'd12);

    // reduced brightness, then async reset mid-slot
    blink_en = 4'b0000; bright = 4'd3;
    wait_ft(); wait_ft(); skip(20);
    bright = 4'd15;
    wait_ft(); skip(4);
    chk("t6_pre_rst_an", 32'(an), 32'hE);
    #2 rst = 1'b1;
    #1 chk("t6_rst_an", 32'(an), 32'hF);
    chk("t6_rst_seg", 32'(segment), 32'hFF);
    chk("t6_rst_ft", 32'(frame_tick), 32'd0);
    skip(2);
    rst = 1'b0;
    skip(40);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
